// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline control logic.
package pipeline_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   localparam logic [4:0]  REG_ZERO = 5'd0;

   // Instruction the pipeline registers load when flushed or bubbled (addi x0,x0,0).
   localparam logic [31:0] NOP = 32'h00000013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a synchronous clear wins over an increment in the same cycle.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: load-use stalls, branch redirect with multi-cycle IF/ID flush,
// memory-busy freeze, and performance counters for the branch-prediction study.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int          CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_valid,
   input  logic             ex_branch_taken,
   input  logic             ex_pred_taken,
   input  logic             ex_target_mismatch,
   input  logic             mem_busy,
   input  logic             clr_counters,
   output logic             pc_write,
   output logic             pc_redirect,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_bubble,
   output logic             ex_mem_write,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] mispredicts
);

   localparam logic [2:0] FLUSH_INIT = (FLUSH_CYCLES == 0) ? 3'd0 : 3'(FLUSH_CYCLES - 1);

   state_t     state;
   logic [2:0] flush_cnt;
   logic       load_use;
   logic       mispredict;
   logic       stall_inc;
   logic       mispred_inc;

   assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

   assign mispredict = ex_branch_valid &&
                       ((ex_branch_taken != ex_pred_taken) ||
                        (ex_branch_taken && ex_target_mismatch));

   // A load-use stall is only real in RUN; during FLUSH the ID instruction is being killed anyway.
   assign stall_inc   = mem_busy || (!mispredict && (state == RUN) && load_use);
   assign mispred_inc = !mem_busy && mispredict;

   always_comb begin
      pc_write     = 1'b1;
      pc_redirect  = 1'b0;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b1;
      id_ex_bubble = 1'b0;
      ex_mem_write = 1'b1;
      if (mem_busy) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
      end else if (mispredict) begin
         pc_redirect  = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (state == FLUSH) begin
         if_id_flush  = 1'b1;
      end else if (load_use) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   // Recovery FSM; a busy data memory freezes it along with the rest of the pipe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         flush_cnt <= 3'd0;
      end else if (!mem_busy) begin
         if (mispredict) begin
            state     <= (FLUSH_CYCLES == 0) ? RUN : FLUSH;
            flush_cnt <= FLUSH_INIT;
         end else if (state == FLUSH) begin
            if (flush_cnt == 3'd0) begin
               state <= RUN;
            end else begin
               flush_cnt <= flush_cnt - 3'd1;
            end
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc),
      .clr   (clr_counters),
      .count (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_mispred_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (mispred_inc),
      .clr   (clr_counters),
      .count (mispredicts)
   );

endmodule
